dmem_responder: RTL and testbench

- Handshaked data-memory slave; the responder end of the core's load/store port.
- Accepts one request at a time over a valid/ready channel and holds it for a programmable number of wait states.
- Commits writes with byte enables, returns read data and an error flag on a response channel.
- Sits between the pipelined core's memory stage and the word-addressed data store.

---
 rtl/dmem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's load/store port. A request is accepted over a
// valid/ready channel, held for WAIT_STATES cycles, and then answered on a
// response channel. Stores commit their enabled bytes into a word-addressed
// array on the edge that enters the response state. Loads sample the array on
// that same edge. Misaligned or out-of-range accesses never touch the array.
// They are answered with rsp_err=1 and rsp_rdata=0.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (high only when idle)
//   req_write  1 = store, 0 = load
//   req_adr    byte address
//   req_wdata  store data
//   req_be     byte enables, bit i covers bits 8i+7:8i (stores only)
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data, 0 for stores and errors
//   rsp_err    access error (misaligned or out of range)
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam bit          NO_WAIT  = (WAIT_STATES == 32'd0);
   localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 32'd1);
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Offset is computed one bit wider than the address: bit 32 is the borrow
   // and flags an address below BASE_ADDR. BASE_ADDR is word aligned, so the
   // low two offset bits equal the low two address bits.
   function automatic logic addr_error(input logic [32:0] offset);
      addr_error = (offset[1:0] != 2'b00) || offset[32] || (offset[31:0] >= SPAN);
   endfunction

   // Byte-enable merge of a store into the existing word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      merge_bytes = merged;
   endfunction

   state_t          state_r;
   state_t          state_nxt_s;
   logic [3:0]      cnt_r;
   logic [3:0]      cnt_nxt_s;
   logic            req_ready_r;
   logic            rsp_valid_r;
   logic [31:0]     rsp_rdata_r;
   logic            rsp_err_r;

   logic            lat_write_r;
   logic [31:0]     lat_adr_r;
   logic [31:0]     lat_wdata_r;
   logic [3:0]      lat_be_r;

   logic            accept_s;
   logic            enter_resp_s;
   logic            op_write_s;
   logic [31:0]     op_adr_s;
   logic [31:0]     op_wdata_s;
   logic [3:0]      op_be_s;
   logic [32:0]     op_offset_s;
   logic            op_err_s;
   logic [IDX_W-1:0] idx_s;
   logic [31:0]     rsp_word_s;
   logic            commit_s;

   logic [31:0]     mem_r [DEPTH];

   assign accept_s = req_valid & req_ready_r;

   // Operand select: with no wait states the response is formed on the
   // acceptance edge itself, so the live request is used; otherwise the
   // values latched at acceptance are used.
   always_comb begin
      op_write_s = lat_write_r;
      op_adr_s   = lat_adr_r;
      op_wdata_s = lat_wdata_r;
      op_be_s    = lat_be_r;
      if (state_r == ST_IDLE) begin
         op_write_s = req_write;
         op_adr_s   = req_adr;
         op_wdata_s = req_wdata;
         op_be_s    = req_be;
      end else begin
         op_write_s = lat_write_r;
         op_adr_s   = lat_adr_r;
         op_wdata_s = lat_wdata_r;
         op_be_s    = lat_be_r;
      end
   end

   // Address decode and response word for the selected operands.
   always_comb begin
      op_offset_s = {1'b0, op_adr_s} - {1'b0, BASE_ADDR};
      op_err_s    = addr_error(op_offset_s);
      idx_s       = op_offset_s[IDX_W+1:2];
      if (op_write_s || op_err_s) begin
         rsp_word_s = 32'd0;
      end else begin
         rsp_word_s = mem_r[idx_s];
      end
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (NO_WAIT) begin
                  state_nxt_s = ST_RESP;
               end else begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = CNT_LOAD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   assign enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
   // reset is folded in so an aborted transaction can never commit.
   assign commit_s     = enter_resp_s & op_write_s & ~op_err_s & reset;

   // FSM state, counter and registered handshake/response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         req_ready_r <= (state_nxt_s == ST_IDLE);
         rsp_valid_r <= (state_nxt_s == ST_RESP);
         if (enter_resp_s) begin
            rsp_rdata_r <= rsp_word_s;
            rsp_err_r   <= op_err_s;
         end else if (state_nxt_s == ST_IDLE) begin
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
         end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
         end
      end
   end

   // Request capture on the acceptance edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_write_r <= 1'b0;
         lat_adr_r   <= 32'd0;
         lat_wdata_r <= 32'd0;
         lat_be_r    <= 4'd0;
      end else if (accept_s) begin
         lat_write_r <= req_write;
         lat_adr_r   <= req_adr;
         lat_wdata_r <= req_wdata;
         lat_be_r    <= req_be;
      end else begin
         lat_write_r <= lat_write_r;
         lat_adr_r   <= lat_adr_r;
         lat_wdata_r <= lat_wdata_r;
         lat_be_r    <= lat_be_r;
      end
   end

   // Data array: not reset, written only on the commit edge.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         mem_r[idx_s] <= merge_bytes(mem_r[idx_s], op_wdata_s, op_be_s);
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share one request bus: u_a (DEPTH 64, base 0, 2 wait states)
// and u_b (DEPTH 16, base 0x1000, no wait states). Only one is ever offered a
// request at a time (selected by sel). Expected values come from a byte-level
// memory model indexed by (addr - base) / 4 with a known-byte mask.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        va, vb;
   logic        rsp_ready;
   logic        req_write;
   logic [31:0] req_adr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
   logic [31:0] rd_a, rd_b;

   bit          sel;
   logic        cur_rr, cur_rv, cur_re;
   logic [31:0] cur_rd;

   int          errs   = 0;
   int          checks = 0;

   logic [31:0] mdl [2][64];
   logic [3:0]  kn  [2][64];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_a (
      .clk(clk), .reset(reset), .req_valid(va), .req_ready(rr_a),
      .req_write(req_write), .req_adr(req_adr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(re_a)
   );

   dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_b (
      .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rr_b),
      .req_write(req_write), .req_adr(req_adr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(re_b)
   );

   assign cur_rr = sel ? rr_b : rr_a;
   assign cur_rv = sel ? rv_b : rv_a;
   assign cur_re = sel ? re_b : re_a;
   assign cur_rd = sel ? rd_b : rd_a;

   // ---------------- reference model ----------------
   function automatic logic [31:0] base_of(input bit s);
      return s ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   function automatic int depth_of(input bit s);
      return s ? 16 : 64;
   endfunction

   function automatic int ws_of(input bit s);
      return s ? 0 : 2;
   endfunction

   function automatic bit exp_err(input bit s, input logic [31:0] a);
      longint ua, lo, hi;
      ua = longint'(a);
      lo = longint'(base_of(s));
      hi = lo + 4 * depth_of(s);
      return (ua % 4 != 0) || (ua < lo) || (ua >= hi);
   endfunction

   function automatic int widx(input bit s, input logic [31:0] a);
      return int'((a - base_of(s)) / 4);
   endfunction

   function automatic logic [31:0] bytemask(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   task automatic model_store(input bit s, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
      int ix;
      if (!exp_err(s, a)) begin
         ix = widx(s, a);
         for (int i = 0; i < 4; i++) begin
            if (b[i]) mdl[s][ix][8*i +: 8] = d[8*i +: 8];
         end
         kn[s][ix] = kn[s][ix] | b;
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) vb = v;
      else va = v;
   endtask

   // One complete transaction on the selected responder. Called #1 after a
   // rising edge. lat counts rising edges after the acceptance edge before
   // rsp_valid is seen, so the response is taken on edge (acceptance+lat+1).
   task automatic run_xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input int hold, input bit early,
                           output int lat, output logic [31:0] rd, output logic e,
                           output bit hold_ok, output bit done_ok);
      int guard;
      req_write = w; req_adr = a; req_wdata = d; req_be = b; rsp_ready = 1'b0;
      set_valid(1'b1);
      guard = 0;
      while (!cur_rr && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      set_valid(1'b0);
      req_write = 1'($urandom); req_adr = $urandom; req_wdata = $urandom;
      req_be = 4'($urandom);
      rsp_ready = early;
      lat = 0;
      while (!cur_rv && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      rsp_ready = 1'b0;
      rd = cur_rd; e = cur_re; hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (!cur_rv || cur_rd !== rd || cur_re !== e || cur_rr !== 1'b0) hold_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      done_ok = (cur_rv === 1'b0) && (cur_rr === 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; va = 1'b0; vb = 1'b0; rsp_ready = 1'b0;
      req_write = 1'b0; req_adr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rr_a, rv_a, re_a, rd_a} !== 35'd0)
         $display("FAIL reset_a: got %h, expected 0", {rr_a, rv_a, re_a, rd_a});
      checks++;
      if ({rr_b, rv_b, re_b, rd_b} !== 35'd0)
         $display("FAIL reset_b: got %h, expected 0", {rr_b, rv_b, re_b, rd_b});
      if ({rr_a, rv_a, re_a, rd_a} !== 35'd0) errs++;
      if ({rr_b, rv_b, re_b, rd_b} !== 35'd0) errs++;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rr_a, rr_b, rv_a, rv_b} !== 4'b1100) begin
         errs++;
         $display("FAIL ready_after_reset: got %b, expected 1100", {rr_a, rr_b, rv_a, rv_b});
      end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd; logic e; bit h, dn;
      sel = 1'b0;
      run_xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
      model_store(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
      checks++;
      if (lat !== 2) begin errs++; $display("FAIL store_latency: got %0d, expected 2", lat); end
      checks++;
      if ({e, rd} !== 33'd0) begin errs++; $display("FAIL store_rsp: got %h, expected 0", {e, rd}); end
      checks++;
      if (!dn) begin errs++; $display("FAIL store_done: got 0, expected 1"); end
      run_xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
         errs++; $display("FAIL load_10: got %h/%b, expected deadbeef/0", rd, e);
      end
   endtask

   task automatic test_byte_enables();
      int lat; logic [31:0] rd; logic e; bit h, dn;
      sel = 1'b0;
      run_xact(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0, lat, rd, e, h, dn);
      model_store(1'b0, 32'h10, 32'h11223344, 4'b0101);
      run_xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if (rd !== 32'hDE22BE44) begin errs++; $display("FAIL byte_en: got %h, expected de22be44", rd); end
      run_xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, lat, rd, e, h, dn);
      run_xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if (rd !== 32'hDE22BE44) begin errs++; $display("FAIL be_zero_noop: got %h, expected de22be44", rd); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic e; bit h, dn;
      sel = 1'b0;
      run_xact(1'b1, 32'h0, 32'h5A5A1234, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
      model_store(1'b0, 32'h0, 32'h5A5A1234, 4'hF);
      run_xact(1'b0, 32'h12, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b1, 32'd0}) begin errs++; $display("FAIL misaligned_load: got %b/%h, expected 1/0", e, rd); end
      run_xact(1'b1, 32'h100, 32'h99999999, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b1, 32'd0}) begin errs++; $display("FAIL oor_store: got %b/%h, expected 1/0", e, rd); end
      run_xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b0, 32'h5A5A1234}) begin errs++; $display("FAIL word0_intact: got %b/%h, expected 0/5a5a1234", e, rd); end
      run_xact(1'b1, 32'hFC, 32'h0BADCAFE, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
      model_store(1'b0, 32'hFC, 32'h0BADCAFE, 4'hF);
      run_xact(1'b0, 32'hFC, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b0, 32'h0BADCAFE}) begin errs++; $display("FAIL last_word: got %b/%h, expected 0/0badcafe", e, rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd0; int lat; bit ok;
      sel = 1'b0;
      req_write = 1'b0; req_adr = 32'h10; rsp_ready = 1'b0; va = 1'b1;
      @(posedge clk); #1;
      // accepted on that edge; present the next request immediately
      req_adr = 32'h0;
      lat = 0;
      while (!rv_a && lat < 40) begin @(posedge clk); #1; lat++; end
      rd0 = rd_a;
      checks++;
      if (rd0 !== mdl[0][4]) begin errs++; $display("FAIL bp_first_rdata: got %h, expected %h", rd0, mdl[0][4]); end
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (rv_a !== 1'b1 || rd_a !== rd0 || rr_a !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errs++; $display("FAIL bp_hold: got unstable, expected stable"); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if ({rv_a, rr_a} !== 2'b01) begin errs++; $display("FAIL bp_release: got %b, expected 01", {rv_a, rr_a}); end
      @(posedge clk); #1;
      va = 1'b0;
      checks++;
      if (rr_a !== 1'b0) begin errs++; $display("FAIL bp_next_accept: got %b, expected 0", rr_a); end
      lat = 0;
      while (!rv_a && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 2 || rd_a !== mdl[0][0]) begin
         errs++; $display("FAIL bp_second: got %0d/%h, expected 2/%h", lat, rd_a, mdl[0][0]);
      end
      rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd; logic e; bit h, dn, ok;
      logic [31:0] d;
      sel = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d = $urandom;
         run_xact(1'b1, 32'h1000 + 32'(4 * k), d, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
         model_store(1'b1, 32'h1000 + 32'(4 * k), d, 4'hF);
      end
      checks++;
      if (lat !== 0) begin errs++; $display("FAIL ws0_latency: got %0d, expected 0", lat); end
      req_write = 1'b0; req_adr = 32'h1000; rsp_ready = 1'b1; vb = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (rv_b !== 1'b1 || rr_b !== 1'b0 || rd_b !== mdl[1][k]) ok = 1'b0;
         req_adr = 32'h1000 + 32'(4 * ((k + 1) % 4));
         @(posedge clk); #1;
         if (rv_b !== 1'b0 || rr_b !== 1'b1) ok = 1'b0;
      end
      vb = 1'b0; rsp_ready = 1'b0;
      checks++;
      if (!ok) begin errs++; $display("FAIL ws0_b2b: got bad pattern, expected accept every 2 cycles"); end
      run_xact(1'b0, 32'h0FFC, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b1, 32'd0}) begin errs++; $display("FAIL below_base: got %b/%h, expected 1/0", e, rd); end
      run_xact(1'b0, 32'h1040, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if ({e, rd} !== {1'b1, 32'd0}) begin errs++; $display("FAIL past_end: got %b/%h, expected 1/0", e, rd); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic e; bit h, dn;
      sel = 1'b0;
      run_xact(1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
      model_store(1'b0, 32'h20, 32'h0, 4'hF);
      req_write = 1'b1; req_adr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; va = 1'b1;
      @(posedge clk); #1;
      va = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({rv_a, rr_a} !== 2'b00) begin errs++; $display("FAIL reset_in_wait: got %b, expected 00", {rv_a, rr_a}); end
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rr_a !== 1'b1) begin errs++; $display("FAIL ready_after_abort: got %b, expected 1", rr_a); end
      run_xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, lat, rd, e, h, dn);
      checks++;
      if (rd !== 32'h0) begin errs++; $display("FAIL dropped_store: got %h, expected 0", rd); end
      // abort while a load response is being held
      req_write = 1'b0; req_adr = 32'h10; va = 1'b1; rsp_ready = 1'b0;
      @(posedge clk); #1;
      va = 1'b0;
      lat = 0;
      while (!rv_a && lat < 40) begin @(posedge clk); #1; lat++; end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({rv_a, re_a, rd_a} !== 34'd0) begin errs++; $display("FAIL reset_in_resp: got %h, expected 0", {rv_a, re_a, rd_a}); end
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random(input bit s, input int n);
      int lat, k, hold, r; logic [31:0] rd, a, d, erd, msk; logic e, ee; bit h, dn, w, early;
      logic [3:0] b;
      sel = s;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         a = base_of(s) + 32'(4 * i);
         run_xact(1'b1, a, d, 4'hF, 0, 1'b0, lat, rd, e, h, dn);
         model_store(s, a, d, 4'hF);
      end
      for (int t = 0; t < n; t++) begin
         r = int'($urandom_range(0, 9));
         k = int'($urandom_range(0, 7));
         if (r < 7) a = base_of(s) + 32'(4 * k);
         else if (r == 7) a = base_of(s) + 32'(4 * k) + 32'($urandom_range(1, 3));
         else if (r == 8) a = base_of(s) + 32'(4 * depth_of(s)) + 32'(4 * $urandom_range(0, 15));
         else a = s ? base_of(s) - 32'(4 * $urandom_range(1, 8)) : 32'hFFFF_FFFC;
         w = 1'($urandom); d = $urandom; b = 4'($urandom);
         hold = int'($urandom_range(0, 3)); early = 1'($urandom);
         ee = exp_err(s, a);
         if (w || ee) begin erd = 32'd0; msk = 32'hFFFF_FFFF; end
         else begin erd = mdl[s][widx(s, a)]; msk = bytemask(kn[s][widx(s, a)]); end
         run_xact(w, a, d, b, hold, early, lat, rd, e, h, dn);
         if (w) model_store(s, a, d, b);
         checks++;
         if (lat !== ws_of(s) || e !== ee || (rd & msk) !== (erd & msk) || !h || !dn) begin
            errs++;
            $display("FAIL random_%0d_%0d: got lat=%0d err=%b rdata=%h hold=%b done=%b, expected lat=%0d err=%b rdata=%h hold=1 done=1 (adr=%h wr=%b)",
                     s, t, lat, e, rd, h, dn, ws_of(s), ee, erd, a, w);
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++) begin
            mdl[s][i] = 32'd0;
            kn[s][i]  = 4'd0;
         end
      sel = 1'b0;
      test_reset();
      test_store_load();
      test_byte_enables();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random(1'b0, 30);
      test_random(1'b1, 30);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
